paint_writer: RTL
=================

Name: paint_writer

Overview:
- Consumer end of the grid paint interface.
- Accepts up to two paint commands per cycle from the game grid: a player-head paint and a wall paint. Each command carries a 12-bit {y,x} cell position and a 4-bit colour value.
- Buffers commands in a small FIFO and drains them, one per cycle, into the write port of the 64x64x4 framebuffer RAM that the VGA scanner reads.
- Owns framebuffer initialisation: after reset and on every clear request it sweeps all cells to the background value.

Parameters:
- GRID_BITS, 6, bits per axis; grid is 2^GRID_BITS x 2^GRID_BITS cells; address width AW = 2*GRID_BITS.
- VAL_W, 4, width of the paint value.
- FIFO_DEPTH, 8, command FIFO entries; must be a power of two and at least 2.
- BG_VAL, 0, value written to every cell during a clear sweep.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- play_en  in  1  player-head paint command valid this cycle.
- play_pos  in  AW  player cell; [GRID_BITS-1:0]=x, [AW-1:GRID_BITS]=y.
- play_val  in  VAL_W  player paint value.
- wall_en  in  1  wall paint command valid this cycle.
- wall_pos  in  AW  wall cell, same packing as play_pos.
- wall_val  in  VAL_W  wall paint value.
- clear_req  in  1  single-cycle request to flush the FIFO and repaint the whole grid with BG_VAL.
- fb_we  out  1  framebuffer write strobe.
- fb_addr  out  AW  framebuffer address = {y,x}, i.e. y*2^GRID_BITS + x.
- fb_data  out  VAL_W  framebuffer write data.
- busy  out  1  high while in CLEAR.
- fifo_count  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky flag: commands were dropped.

Behaviour:
- Reset (reset=0, async): FIFO emptied, fifo_count=0, overflow=0, fb_we=0, fb_addr=0, fb_data=0. State=CLEAR with sweep counter=0, so busy=1 immediately.
- Outputs fb_we, fb_addr and fb_data are registered.
- States: CLEAR and RUN.
- CLEAR:
  - Each cycle: fb_we=1, fb_addr=sweep counter, fb_data=BG_VAL; the counter then increments.
  - The write to the last address (all ones) is the final CLEAR cycle. Next state is RUN, busy=0.
  - A full sweep is exactly 2^AW cycles of fb_we=1 (4096 at default).
- RUN:
  - If the FIFO is non-empty, pop the head and present it on fb_* with fb_we=1 the next cycle.
  - If the FIFO is empty, fb_we=0; fb_addr and fb_data hold their last values.
- Push rules (evaluated in both states, except in a clear_req cycle):
  - Required slots = wall_en + play_en.
  - If free slots >= required: push the wall entry first, then the player entry, so the head is drawn over the wall at the same cell.
  - If free slots < required: both commands are dropped (no partial push) and overflow is set.
  - Free slots are computed before this cycle's pop; a simultaneous pop does not create space for the same cycle's push.
- Latency: a command pushed in cycle N into an empty FIFO while in RUN appears with fb_we=1 in cycle N+2 (FIFO write, then registered output).
- Throughput: one framebuffer write per cycle. The FIFO does not drain during CLEAR; pushes made during CLEAR are kept and drained after the sweep.
- clear_req=1 (any state):
  - Next cycle the FIFO is flushed, fifo_count=0, overflow=0, sweep counter=0, state=CLEAR.
  - Pushes presented in the clear_req cycle are discarded.
  - clear_req during CLEAR restarts the sweep from address 0.
- Pointer arithmetic: read and write pointers wrap modulo FIFO_DEPTH. fifo_count distinguishes full from empty and never exceeds FIFO_DEPTH.
- Position inputs are used verbatim; no range checking is needed because every AW-bit value is a legal cell.

Test Plan:
- Reset then idle: release reset, keep all inputs 0 -> busy=1 for 4096 cycles, fb_we=1 each cycle with fb_addr 0..4095 and fb_data=0; then busy=0 and fb_we=0 on the next cycle.
- Dual push after clear: in RUN, one cycle with wall_en=1, wall_pos=0x041, wall_val=0x5 and play_en=1, play_pos=0x041, play_val=0x1 -> fifo_count=2; fb_we writes (0x041,0x5) then (0x041,0x1) on consecutive cycles; fifo_count returns to 0.
- Overflow: fire clear_req, then during CLEAR push 5 dual-command cycles -> first 4 cycles accepted (fifo_count=8), 5th dropped and overflow=1. After the sweep, exactly 8 writes in push order; overflow stays 1.
- Clear mid-drain: with the FIFO holding 6 entries in RUN, pulse clear_req -> fifo_count=0 and overflow=0 next cycle; sweep restarts at address 0; none of the 6 entries is ever written.
- Async reset mid-sweep: assert reset at sweep address 1000 without a clock edge -> fb_we=0, fb_addr=0 and fifo_count=0 immediately; on release the sweep restarts at address 0.
- Single-source pushes: play_en only, 3 consecutive cycles with pos 0x000, 0xFFF, 0x7C0 and val 0x2 -> three writes in that order, the first appearing 2 cycles after its push.

Source files
------------

// File: rtl/paint_writer.sv
// paint_writer: consumer end of the grid paint interface.
//
// Accepts up to two paint commands per cycle (wall and player head) into a
// small FIFO and drains one command per cycle into the framebuffer write
// port. After reset, and on every clear_req, it sweeps every framebuffer
// cell to BG_VAL before draining resumes.
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous active-low reset
//   play_en     player-head paint valid; play_pos {y,x}; play_val colour
//   wall_en     wall paint valid; wall_pos {y,x}; wall_val colour
//   clear_req   single-cycle request: flush FIFO and repaint grid with BG_VAL
//   fb_we       registered framebuffer write strobe
//   fb_addr     registered framebuffer address {y,x}
//   fb_data     registered framebuffer write data
//   busy        high while the clear sweep is running
//   fifo_count  current FIFO occupancy
//   overflow    sticky: at least one command pair was dropped
module paint_writer #(
  parameter int GRID_BITS  = 6,
  parameter int VAL_W      = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int BG_VAL     = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         play_en,
  input  logic [2*GRID_BITS-1:0]       play_pos,
  input  logic [VAL_W-1:0]             play_val,
  input  logic                         wall_en,
  input  logic [2*GRID_BITS-1:0]       wall_pos,
  input  logic [VAL_W-1:0]             wall_val,
  input  logic                         clear_req,
  output logic                         fb_we,
  output logic [2*GRID_BITS-1:0]       fb_addr,
  output logic [VAL_W-1:0]             fb_data,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow
);
  localparam int AW = 2 * GRID_BITS;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = AW + VAL_W;
  localparam logic [VAL_W-1:0] BG = VAL_W'(BG_VAL);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t            r_state;
  logic [AW-1:0]     r_sweep;
  logic              r_fb_we;
  logic [AW-1:0]     r_fb_addr;
  logic [VAL_W-1:0]  r_fb_data;
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;
  logic [EW-1:0]     r_mem [FIFO_DEPTH];

  state_t            w_state_nxt;
  logic [AW-1:0]     w_sweep_nxt;
  logic              w_we_nxt;
  logic [AW-1:0]     w_addr_nxt;
  logic [VAL_W-1:0]  w_data_nxt;
  logic              w_pop;
  logic [EW-1:0]     w_head;
  logic [CW-1:0]     w_req;
  logic [CW-1:0]     w_free;
  logic              w_fits;
  logic              w_push_wall;
  logic              w_push_play;
  logic              w_drop;
  logic [CW-1:0]     w_npush;
  logic [PW-1:0]     w_play_slot;

  assign w_head = r_mem[r_rptr];

  // Free space is taken before this cycle's pop, so a pop never makes room
  // for a same-cycle push. Pushes are all-or-nothing.
  assign w_req       = CW'(wall_en) + CW'(play_en);
  assign w_free      = CW'(FIFO_DEPTH) - r_count;
  assign w_fits      = (w_free >= w_req);
  assign w_push_wall = !clear_req && w_fits && wall_en;
  assign w_push_play = !clear_req && w_fits && play_en;
  assign w_drop      = !clear_req && !w_fits;
  assign w_npush     = CW'(w_push_wall) + CW'(w_push_play);
  // Wall goes in first so the head lands on top when both hit one cell.
  assign w_play_slot = r_wptr + PW'(w_push_wall);

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_sweep_nxt = r_sweep;
    w_pop       = 1'b0;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_fb_addr;
    w_data_nxt  = r_fb_data;
    if (clear_req) begin
      // The clear cycle itself writes nothing; the sweep starts next cycle.
      w_state_nxt = S_CLEAR;
      w_sweep_nxt = '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          w_we_nxt    = 1'b1;
          w_addr_nxt  = r_sweep;
          w_data_nxt  = BG;
          w_sweep_nxt = r_sweep + 1'b1;
          if (r_sweep == '1) w_state_nxt = S_RUN;
        end
        S_RUN: begin
          if (r_count != '0) begin
            w_pop      = 1'b1;
            w_we_nxt   = 1'b1;
            w_addr_nxt = w_head[EW-1:VAL_W];
            w_data_nxt = w_head[VAL_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // State, sweep counter and registered framebuffer port
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_CLEAR;
      r_sweep   <= '0;
      r_fb_we   <= 1'b0;
      r_fb_addr <= '0;
      r_fb_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_sweep   <= w_sweep_nxt;
      r_fb_we   <= w_we_nxt;
      r_fb_addr <= w_addr_nxt;
      r_fb_data <= w_data_nxt;
    end
  end

  // FIFO control
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (clear_req) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wptr  <= r_wptr + PW'(w_npush);
      r_rptr  <= r_rptr + PW'(w_pop);
      r_count <= r_count + w_npush - CW'(w_pop);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // FIFO storage (data only, no reset)
  always_ff @(posedge clock) begin
    if (w_push_wall) r_mem[r_wptr] <= {wall_pos, wall_val};
    if (w_push_play) r_mem[w_play_slot] <= {play_pos, play_val};
  end

  assign fb_we      = r_fb_we;
  assign fb_addr    = r_fb_addr;
  assign fb_data    = r_fb_data;
  assign busy       = (r_state == S_CLEAR);
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule
